// File: rtl/pifo_dequeue_engine_pkg.sv
// Shared PIFO header types for the dequeue side.
//   Priority      : head priority; a lower numeric value means higher precedence
//   PacketPointer : opaque packet handle, passed through unmodified
//   pifo_entry_t  : {priority, pointer} pair as held in the output buffer
//   deq_state_t   : dequeue engine FSM states
package pifo_dequeue_engine_pkg;

    localparam int PRIORITY_WIDTH = 8;
    localparam int POINTER_WIDTH  = 16;

    typedef logic [PRIORITY_WIDTH-1:0] Priority;
    typedef logic [POINTER_WIDTH-1:0]  PacketPointer;

    typedef struct packed {
        Priority      prio;
        PacketPointer pointer;
    } pifo_entry_t;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        READY    = 2'd1,
        GAP      = 2'd2
    } deq_state_t;

    // Unsigned compare; a threshold of all-ones admits every head.
    function automatic logic is_eligible(input Priority prio, input Priority threshold);
        return prio <= threshold;
    endfunction

endpackage

// File: rtl/pifo_out_buffer.sv
// Two-entry registered valid/ready FIFO holding popped PIFO entries.
//   clk, reset  : clock, asynchronous active-high reset
//   push        : write push_entry (only honoured while space=1)
//   push_entry  : entry to write
//   flush       : discard all buffered entries next cycle
//   out_valid   : head entry valid (registered)
//   out_entry   : head entry (registered, stable while out_valid & !out_ready)
//   out_ready   : downstream accept
//   space       : a push can be taken this cycle
//   occ         : current occupancy, 0..2
module pifo_out_buffer
    import pifo_dequeue_engine_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  pifo_entry_t push_entry,
    input  logic        flush,
    output logic        out_valid,
    output pifo_entry_t out_entry,
    input  logic        out_ready,
    output logic        space,
    output logic [1:0]  occ
);

    pifo_entry_t slot0;
    pifo_entry_t slot1;
    logic [1:0]  occ_q;
    logic        fire;

    assign fire      = (occ_q != 2'd0) & out_ready;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign space     = (occ_q != 2'd2) | fire;
    assign out_valid = (occ_q != 2'd0);
    assign out_entry = slot0;
    assign occ       = occ_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot0 <= '0;
            slot1 <= '0;
            occ_q <= 2'd0;
        end else if (flush) begin
            occ_q <= 2'd0;
        end else begin
            case ({push, fire})
                2'b11: begin
                    // Occupancy is unchanged; the new entry lands behind what remains.
                    if (occ_q == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= push_entry;
                    end else begin
                        slot0 <= push_entry;
                    end
                end
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        slot0 <= push_entry;
                        occ_q <= 2'd1;
                    end else if (occ_q == 2'd1) begin
                        slot1 <= push_entry;
                        occ_q <= 2'd2;
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                    occ_q <= occ_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pifo_dequeue_engine.sv
// Reader-side PIFO client: pops eligible heads with a programmable minimum
// gap between pops and hands them downstream through a 2-entry buffer.
//   clk, reset                  : clock, asynchronous active-high reset
//   i__pifo_empty/priority/...  : PIFO head view (combinational from PIFO)
//   o__pifo_dequeue             : pop strobe to the PIFO (combinational)
//   i__enable                   : run enable
//   i__priority_threshold       : head eligible iff priority <= threshold
//   i__min_gap                  : idle cycles enforced after each pop
//   i__flush                    : discard buffered entries
//   o__data_out_*, i__data_out_ready : downstream valid/ready interface
//   o__dequeue_count            : pops since reset, wrapping
//   o__busy                     : buffer non-empty or pacing gap in progress
//
// state    | meaning
// ---------+------------------------------------------------------------
// DISABLED | engine off; no pops, gap counter held at zero
// READY    | pop whenever the head is eligible and the buffer has space
// GAP      | pacing after a pop; counts down to release the next pop
module pifo_dequeue_engine
    import pifo_dequeue_engine_pkg::*;
#(
    parameter int GAP_WIDTH   = 8,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i__pifo_empty,
    input  Priority                i__pifo_priority,
    input  PacketPointer           i__pifo_packet_pointer,
    output logic                   o__pifo_dequeue,
    input  logic                   i__enable,
    input  Priority                i__priority_threshold,
    input  logic [GAP_WIDTH-1:0]   i__min_gap,
    input  logic                   i__flush,
    output logic                   o__data_out_valid,
    output Priority                o__data_out_priority,
    output PacketPointer           o__data_out,
    input  logic                   i__data_out_ready,
    output logic [COUNT_WIDTH-1:0] o__dequeue_count,
    output logic                   o__busy
);

    deq_state_t             state;
    logic [GAP_WIDTH-1:0]   gap_count;
    logic [COUNT_WIDTH-1:0] dequeue_count;
    logic                   pop;
    logic                   buf_space;
    logic [1:0]             buf_occ;
    pifo_entry_t            head_entry;
    pifo_entry_t            out_entry;

    assign head_entry = '{prio: i__pifo_priority, pointer: i__pifo_packet_pointer};

    // An ineligible head simply yields no pop this cycle; the FSM stays in READY.
    assign pop = (state == READY)
               & !i__pifo_empty
               & is_eligible(i__pifo_priority, i__priority_threshold)
               & buf_space
               & !i__flush;

    assign o__pifo_dequeue = pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= DISABLED;
            gap_count <= '0;
        end else if (!i__enable) begin
            state     <= DISABLED;
            gap_count <= '0;
        end else begin
            case (state)
                DISABLED: state <= READY;
                READY: begin
                    // min_gap is sampled only here, so mid-gap changes do not
                    // disturb the gap already in progress.
                    if (pop && (i__min_gap != '0)) begin
                        gap_count <= i__min_gap;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    // Leaving at a count of 1 yields exactly min_gap idle cycles.
                    if (gap_count <= GAP_WIDTH'(1)) begin
                        gap_count <= '0;
                        state     <= READY;
                    end else begin
                        gap_count <= gap_count - GAP_WIDTH'(1);
                    end
                end
                default: state <= DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dequeue_count <= '0;
        end else if (pop) begin
            dequeue_count <= dequeue_count + COUNT_WIDTH'(1);
        end
    end

    pifo_out_buffer u_out_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (pop),
        .push_entry (head_entry),
        .flush      (i__flush),
        .out_valid  (o__data_out_valid),
        .out_entry  (out_entry),
        .out_ready  (i__data_out_ready),
        .space      (buf_space),
        .occ        (buf_occ)
    );

    assign o__data_out_priority = out_entry.prio;
    assign o__data_out          = out_entry.pointer;
    assign o__dequeue_count     = dequeue_count;
    assign o__busy              = (buf_occ != 2'd0) | (state == GAP);

endmodule

// File: doc/pifo_dequeue_engine.md
Name: pifo_dequeue_engine

Overview:
- Reader-side client of the PIFO: pops the head entry when the PIFO is non-empty, the head is eligible, and the pacing gap has elapsed.
- Buffers popped entries in a 2-entry output queue with registered outputs, and presents them to the downstream transmit path over a valid/ready interface.
- Sits between the `pifo` dequeue port and the packet-fetch/transmit logic.

Parameters:
- GAP_WIDTH, 8, width of the programmable minimum inter-pop gap.
- COUNT_WIDTH, 32, width of the popped-packet counter.

Ports:
- clk  input  1  clock.
- reset  input  1  reset; asynchronous, active-high.
- i__pifo_empty  input  1  PIFO empty flag.
- i__pifo_priority  input  $bits(Priority)  head priority, combinational from PIFO.
- i__pifo_packet_pointer  input  $bits(PacketPointer)  head pointer, combinational from PIFO.
- o__pifo_dequeue  output  1  pop strobe to PIFO; combinational.
- i__enable  input  1  run enable.
- i__priority_threshold  input  $bits(Priority)  head eligible iff priority <= threshold.
- i__min_gap  input  GAP_WIDTH  minimum idle cycles between consecutive pops.
- i__flush  input  1  synchronous discard of buffered entries.
- o__data_out_valid  output  1  output entry valid.
- o__data_out_priority  output  $bits(Priority)  output priority.
- o__data_out  output  $bits(PacketPointer)  output packet pointer.
- i__data_out_ready  input  1  downstream accept.
- o__dequeue_count  output  COUNT_WIDTH  total pops since reset; wraps.
- o__busy  output  1  high when the buffer is non-empty or the FSM is in GAP.

Behaviour:
- Reset (async, active-high): buffer empty, FSM=DISABLED, gap counter=0, count=0.
  - Resulting outputs: o__data_out_valid=0, data and priority outputs=0, o__pifo_dequeue=0, o__busy=0.
- Output buffer: 2-entry FIFO, occ in 0..2.
  - Head drives the outputs from registers.
  - Downstream fire = valid & ready.
  - Payload is held stable while valid & !ready.
- space = (occ<2) | fire.
- FSM states:
  - DISABLED: while !i__enable. Goes to READY when i__enable=1.
  - READY: o__pifo_dequeue = !i__pifo_empty & (i__pifo_priority <= i__priority_threshold) & space & !i__flush.
    - On a pop: the head is captured into the buffer in the same cycle.
    - If i__min_gap==0, stay in READY (back-to-back pops allowed). Otherwise load gap counter = i__min_gap and go to GAP.
  - GAP: no pop; the counter decrements each cycle. Return to READY when the counter reaches 1, so exactly i__min_gap non-pop cycles occur between pops.
  - Any state with i__enable=0 goes to DISABLED next cycle. The gap counter clears; buffered entries still drain downstream.
- Pop-to-output latency:
  - 1 cycle when the buffer is empty: popped entry valid on the next cycle.
  - Otherwise the entry is queued behind existing entries.
- Simultaneous pop and fire with occ==2: allowed; occ stays 2 and ordering is preserved.
- i__flush:
  - occ goes to 0 next cycle; any fire in that cycle is still counted as accepted by the downstream.
  - o__pifo_dequeue is forced 0 that cycle.
  - FSM state and the gap counter are unaffected.
- o__dequeue_count increments on every pop (o__pifo_dequeue=1) and wraps at 2^COUNT_WIDTH.
- Comparison is unsigned, numeric lower value = higher precedence. Threshold = max Priority makes every head eligible.
- i__min_gap is sampled only at a pop. Changing it mid-GAP does not affect the current gap.
- A head that is ineligible does not block the FSM; the engine stays in READY and re-evaluates every cycle.
- Pointers and priorities pass through unmodified and are never reordered.

Decomposition:
- Priority, PacketPointer and the state enum (DISABLED/READY/GAP) live in the shared pifo headers package.
- GAP_WIDTH and COUNT_WIDTH stay local parameters.
- One natural sub-module: pifo_out_buffer, a 2-entry registered valid/ready FIFO with a flush input.

Test Plan:
- Basic drain, min_gap=0, threshold=max, ready=1: PIFO preloaded with priorities 3,5,9 -> pops on 3 consecutive cycles; outputs 3,5,9 on the following 3 cycles; count=3.
- Pacing, min_gap=2: 3 entries -> pops at cycles t, t+3, t+6; no pop strobe in between.
- Backpressure, ready=0: 4 entries -> exactly 2 pops, then dequeue stays 0 and the output is stable. Raising ready -> remaining 2 pop, in order.
- Eligibility, threshold=4, head priority 7: no pop. Lowering threshold changes nothing; raising threshold to 7 -> pop next cycle.
- Flush with occ=2: flush=1 -> valid=0 next cycle, no pop that cycle; count unchanged by the flush.
- Async reset mid-GAP with valid=1: all outputs 0 immediately, before the next clock edge. After release with enable=1, normal pops resume.
